// File: rtl/game_pkg.sv
// Shared constants and types for the invader formation fire logic.
package game_pkg;

  localparam int N_COLS = 8;
  localparam int N_ROWS = 3;
  localparam int ID_W   = 6;

  // Galois form of x^16+x^14+x^13+x^11, right-shifting
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    COOL,
    PICK,
    SCAN,
    FIRE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; loads the seed while reset is held.
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  import game_pkg::*;

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Chooses a random column, fires from its bottom-most live invader, and
// rate-limits shots around the single enemy bullet's busy flag.
//   IDLE disabled | COOL cooldown / wait bullet free | PICK random column
//   SCAN one column per cycle | FIRE spawn pulse | WAIT_ACK bullet start
//   WAIT_DONE bullet in flight
module enemy_fire_scheduler #(
  parameter int          N_COLS      = game_pkg::N_COLS,
  parameter int          N_ROWS      = game_pkg::N_ROWS,
  parameter int          ID_W        = game_pkg::ID_W,
  parameter int          COOLDOWN    = 25_000_000,
  parameter int          ACK_TIMEOUT = 16,
  parameter logic [15:0] LFSR_SEED   = game_pkg::LFSR_SEED
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     restart,
  input  logic [N_ROWS*N_COLS-1:0] vivo_inimigo,
  input  logic                     shot_busy,
  output logic                     fire,
  output logic [ID_W-1:0]          ID_enemy_tiro,
  output logic                     no_shooter
);
  import game_pkg::*;

  localparam int N_BITS = N_ROWS * N_COLS;
  localparam int VEC_W  = 1 << ID_W;
  localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int CNT_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int ACK_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] COOL_RELOAD = CNT_W'(COOLDOWN - 1);
  localparam logic [ACK_W-1:0] ACK_RELOAD  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [COL_W-1:0] LAST_TRY    = COL_W'(N_COLS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACK_W-1:0]  ack_q, ack_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [COL_W-1:0]  tries_q, tries_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              no_shooter_q, no_shooter_d;

  logic [15:0]       lfsr_q;
  logic [VEC_W-1:0]  vivo_ext;
  logic [ID_W:0]     pick;
  logic              unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:COL_W];

  // Zero-extended so any ID_W-bit index is in range.
  assign vivo_ext = VEC_W'(vivo_inimigo);

  // Returns {found, id} for the highest live row in the given column.
  function automatic logic [ID_W:0] bottom_pick(input logic [N_BITS-1:0] vivo,
                                                input logic [COL_W-1:0]  col);
    logic [ID_W:0]     res;
    logic [N_COLS-1:0] row_bits;
    res = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      row_bits = vivo[r*N_COLS +: N_COLS];
      if (row_bits[col]) begin
        res = {1'b1, ID_W'(r) * ID_W'(N_COLS) + ID_W'(col)};
      end
    end
    return res;
  endfunction

  assign pick = bottom_pick(vivo_inimigo, col_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ack_q        <= '0;
      col_q        <= '0;
      tries_q      <= '0;
      id_q         <= '0;
      no_shooter_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      col_q        <= col_d;
      tries_q      <= tries_d;
      id_q         <= id_d;
      no_shooter_q <= no_shooter_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ack_d        = ack_q;
    col_d        = col_q;
    tries_d      = tries_q;
    id_d         = id_q;
    no_shooter_d = no_shooter_q;

    if (restart) begin
      state_d      = IDLE;
      cnt_d        = '0;
      ack_d        = '0;
      col_d        = '0;
      tries_d      = '0;
      id_d         = '0;
      no_shooter_d = 1'b0;
    end else if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = COOL;
          cnt_d   = COOL_RELOAD;
        end
        COOL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (!shot_busy) begin
            state_d = PICK;
          end
        end
        PICK: begin
          col_d   = lfsr_q[COL_W-1:0];
          tries_d = '0;
          state_d = SCAN;
        end
        SCAN: begin
          if (pick[ID_W]) begin
            id_d         = pick[ID_W-1:0];
            no_shooter_d = 1'b0;
            state_d      = FIRE;
          end else if (tries_q == LAST_TRY) begin
            no_shooter_d = 1'b1;
            state_d      = COOL;
            cnt_d        = COOL_RELOAD;
          end else begin
            col_d   = col_q + 1'b1;
            tries_d = tries_q + 1'b1;
          end
        end
        FIRE: begin
          // A shooter killed between SCAN and FIRE forces a fresh pick.
          if (vivo_ext[id_q]) begin
            state_d = WAIT_ACK;
            ack_d   = ACK_RELOAD;
          end else begin
            state_d = PICK;
          end
        end
        WAIT_ACK: begin
          if (shot_busy) begin
            state_d = WAIT_DONE;
          end else if (ack_q == '0) begin
            state_d = COOL;
            cnt_d   = COOL_RELOAD;
          end else begin
            ack_d = ack_q - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!shot_busy) begin
            state_d = COOL;
            cnt_d   = COOL_RELOAD;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign fire          = (state_q == FIRE) && vivo_ext[id_q];
  assign ID_enemy_tiro = id_q;
  assign no_shooter    = no_shooter_q;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed bench for enemy_fire_scheduler with COOLDOWN=10.
module tb_enemy_fire_scheduler;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        restart;
  logic [23:0] vivo;
  logic        shot_busy;
  logic        fire;
  logic [5:0]  id;
  logic        no_shooter;

  int tests = 0;
  int fails = 0;
  int n;
  int fc;
  int nz;
  int found;

  enemy_fire_scheduler #(.COOLDOWN(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .restart       (restart),
    .vivo_inimigo  (vivo),
    .shot_busy     (shot_busy),
    .fire          (fire),
    .ID_enemy_tiro (id),
    .no_shooter    (no_shooter)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Steps until fire is seen; n = steps taken, or -1 if the budget ran out.
  task automatic wait_fire(input int maxc, output int steps);
    bit done;
    done  = 1'b0;
    steps = -1;
    for (int i = 1; i <= maxc && !done; i++) begin
      step();
      if (fire) begin
        steps = i;
        done  = 1'b1;
      end
    end
  endtask

  task automatic count_fires(input int k, inout int cnt);
    for (int i = 0; i < k; i++) begin
      step();
      if (fire) cnt++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    restart   = 1'b0;
    shot_busy = 1'b0;
    vivo      = 24'h000000;
    step(); step(); step();
    check("rst_fire", int'(fire), 0);
    check("rst_id", int'(id), 0);
    check("rst_no_shooter", int'(no_shooter), 0);
    check("rst_state", int'(dut.state_q), int'(IDLE));

    // Empty formation: first scan ends after cycle 19.
    enable = 1'b1;
    reset  = 1'b0;
    fc = 0;
    count_fires(19, fc);
    check("empty_ns_before", int'(no_shooter), 0);
    step();
    if (fire) fc++;
    check("empty_ns_after", int'(no_shooter), 1);
    nz = 0;
    for (int i = 0; i < 180; i++) begin
      step();
      if (fire) fc++;
      if (!no_shooter) nz++;
    end
    check("empty_no_fire", fc, 0);
    check("empty_ns_stays", nz, 0);

    // Column 3 rows 0 and 1 live: bottom-most is ID 11.
    vivo = 24'h000808;
    wait_fire(60, n);
    check("bottom_seen", int'(n > 0), 1);
    check("bottom_id1", int'(id), 11);
    check("bottom_ns_clear", int'(no_shooter), 0);
    step();
    check("fire_width", int'(fire), 0);
    wait_fire(40, n);
    check_rng("ack_timeout_gap", n + 1, 29, 36);
    check("bottom_id2", int'(id), 11);

    // Handshake: busy right after fire for 50 cycles.
    shot_busy = 1'b1;
    fc = 0;
    count_fires(50, fc);
    check("busy_no_fire", fc, 0);
    shot_busy = 1'b0;
    wait_fire(30, n);
    check_rng("after_busy_gap", n, 13, 20);
    check("after_busy_id", int'(id), 11);

    // Busy raised mid-cooldown holds COOL at zero.
    fc = 0;
    count_fires(20, fc);
    shot_busy = 1'b1;
    count_fires(40, fc);
    check("cool_hold_no_fire", fc, 0);
    shot_busy = 1'b0;
    wait_fire(15, n);
    check_rng("cool_release_gap", n, 3, 10);

    // Enable dropped mid-cooldown.
    fc = 0;
    count_fires(20, fc);
    enable = 1'b0;
    count_fires(5, fc);
    check("disable_no_fire", fc, 0);
    check("disable_id_held", int'(id), 11);
    check("disable_state", int'(dut.state_q), int'(IDLE));
    enable = 1'b1;
    wait_fire(30, n);
    check_rng("reenable_gap", n, 13, 20);

    // Kill race: shooter dies the cycle FIRE is entered.
    step();
    vivo  = 24'h020000;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (dut.state_q == FIRE) found = 1;
    end
    check("kill_fire_state_seen", found, 1);
    vivo = 24'h001000;
    #1;
    check("kill_fire_low", int'(fire), 0);
    check("kill_id_held", int'(id), 17);
    wait_fire(15, n);
    check_rng("kill_repick_gap", n, 3, 10);
    check("kill_new_id", int'(id), 12);

    // Async reset mid-COOL, then exact first-shot latency from seed.
    fc = 0;
    count_fires(20, fc);
    check("pre_reset_no_fire", fc, 0);
    vivo   = 24'h020000;
    enable = 1'b1;
    reset  = 1'b1;
    #1;
    check("async_rst_state", int'(dut.state_q), int'(IDLE));
    check("async_rst_fire", int'(fire), 0);
    check("async_rst_id", int'(id), 0);
    check("async_rst_ns", int'(no_shooter), 0);
    step();
    step();
    reset = 1'b0;
    wait_fire(25, n);
    check("first_shot_latency", n, 14);
    check("first_shot_id", int'(id), 17);
    step();
    check("first_shot_width", int'(fire), 0);

    // Restart wins over enable and clears the ID.
    restart = 1'b1;
    step();
    check("restart_state", int'(dut.state_q), int'(IDLE));
    check("restart_id", int'(id), 0);
    check("restart_fire", int'(fire), 0);
    restart = 1'b0;
    step();
    check("restart_resume", int'(dut.state_q), int'(COOL));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
